seq_step_ctrl: RTL and testbench

//  Sequencing controller for the 3-bit decoder-based state datapath. Owns state register q and decides when q <= next_q.

---
 rtl/seq_step_ctrl.sv | 150 +++++++++++++++
 tb/tb_seq_step_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_step_ctrl.sv
// seq_step_ctrl: sequencing controller for a 3-bit decoder-based state datapath.
// Owns the state register q. It synchronizes the three push buttons and
// arbitrates between load, manual step and auto-run tick, with the priority
// load > run toggle > step. It also measures how many steps the sequence
// takes to return to the seed.
// Optional build macro: SEQ_HISTORY_EN adds a 4-entry history of prior states
// on the hist port. When the macro is undefined, the history flops and the
// port are absent.
module seq_step_ctrl #(
  parameter int         RATE_DIV    = 25,
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] RESET_STATE = 3'b010
) (
  input  logic        hz100,
  input  logic        reset_n,
  input  logic        load_btn,
  input  logic        step_btn,
  input  logic        run_btn,
  input  logic [2:0]  seed,
  input  logic [2:0]  next_q,
  output logic [2:0]  q,
  output logic        step_pulse,
  output logic        running,
  output logic [3:0]  period,
  output logic        period_valid
`ifdef SEQ_HISTORY_EN
  ,
  output logic [11:0] hist
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int            PW         = $clog2(RATE_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(RATE_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  // Button bundle bit order: {run, step, load}
  logic [2:0]    r_sync [SYNC_STAGES];
  logic [2:0]    r_prev;
  logic [2:0]    w_press;
  logic          w_load_press;
  logic          w_step_press;
  logic          w_run_press;

  state_t        r_state;
  logic          r_running;
  logic [PW-1:0] r_presc;
  logic [2:0]    r_q;
  logic [2:0]    r_seed_ref;
  logic [3:0]    r_count;
  logic [3:0]    r_period;
  logic          r_valid;
  logic          w_tick;
  logic          w_step_pulse;
  logic [3:0]    w_count_inc;

  // Synchronize the asynchronous buttons and keep one delayed copy for edge detection
  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      r_sync[0] <= {run_btn, step_btn, load_btn};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // A held button produces exactly one pulse: the cycle after its synchronized rise
  assign w_press      = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_load_press = w_press[0];
  assign w_step_press = w_press[1];
  assign w_run_press  = w_press[2];

  assign w_tick      = (r_state == ST_RUN) && (r_presc == PRESC_LAST);
  assign w_count_inc = (r_count == 4'd15) ? 4'd15 : r_count + 4'd1;

  // Decide whether a step commits this cycle; load and run presses swallow it
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_step_pulse = 1'b0;
    if (!w_load_press && !w_run_press)
      w_step_pulse = (r_state == ST_RUN) ? w_tick : w_step_press;
  end

  // Run/idle FSM with prescaler, state register and period measurement
  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_running  <= 1'b0;
      r_presc    <= '0;
      r_q        <= RESET_STATE;
      r_seed_ref <= RESET_STATE;
      r_count    <= '0;
      r_period   <= '0;
      r_valid    <= 1'b0;
    end else if (w_load_press) begin
      r_state    <= ST_IDLE;
      r_running  <= 1'b0;
      r_presc    <= '0;
      r_q        <= seed;
      r_seed_ref <= seed;
      r_count    <= '0;
      r_period   <= '0;
      r_valid    <= 1'b0;
    end else if (w_run_press) begin
      r_state   <= (r_state == ST_RUN) ? ST_IDLE : ST_RUN;
      r_running <= (r_state != ST_RUN);
      r_presc   <= '0;
    end else begin
      if (r_state == ST_RUN)
        r_presc <= w_tick ? '0 : r_presc + PRESC_ONE;
      if (w_step_pulse) begin
        r_q <= next_q;
        if (next_q == r_seed_ref) begin
          r_period <= w_count_inc;
          r_valid  <= 1'b1;
          r_count  <= '0;
        end else begin
          r_count <= w_count_inc;
        end
      end
    end
  end

  assign q            = r_q;
  assign step_pulse   = w_step_pulse;
  assign running      = r_running;
  assign period       = r_period;
  assign period_valid = r_valid;

`ifdef SEQ_HISTORY_EN
  logic [11:0] r_hist;

  // Shift the departing state into the history on every committed step
  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n)           r_hist <= {4{RESET_STATE}};
    else if (w_load_press)  r_hist <= {4{seed}};
    else if (w_step_pulse)  r_hist <= {r_q, r_hist[11:3]};
  end

  assign hist = r_hist;
`endif

endmodule

// File: tb/tb_seq_step_ctrl.sv
// tb_seq_step_ctrl: directed and random stimulus for seq_step_ctrl. The DUT is
// compared every cycle against a behavioural model kept in this bench. The
// model tracks button presses as scheduled events and expresses the
// step/run/period rules in plain arithmetic.
module tb_seq_step_ctrl;

  localparam int         RATE_DIV = 4;
  localparam int         SYNC     = 2;
  localparam logic [2:0] RST_Q    = 3'b010;
  localparam int         EVN      = 256;
  localparam int         B_LOAD   = 0;
  localparam int         B_STEP   = 1;
  localparam int         B_RUN    = 2;

  logic        hz100 = 1'b0;
  logic        reset_n;
  logic        load_btn, step_btn, run_btn;
  logic [2:0]  seed, next_q, q;
  logic        step_pulse, running, period_valid;
  logic [3:0]  period;
`ifdef SEQ_HISTORY_EN
  logic [11:0] hist;
`endif

  int mode = 0;   // 0: 2->4->6->7->3->0->1->5->2, 1: next state always 0
  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  // Scheduled press events: bit0 load, bit1 step, bit2 run
  bit [2:0]    ev [EVN];

  logic [2:0]  m_q, m_seed;
  logic        m_run, m_valid;
  int          m_phase;
  logic [3:0]  m_count, m_period;
  logic [11:0] m_hist;

  seq_step_ctrl #(.RATE_DIV(RATE_DIV), .SYNC_STAGES(SYNC), .RESET_STATE(RST_Q)) dut (
    .hz100(hz100), .reset_n(reset_n),
    .load_btn(load_btn), .step_btn(step_btn), .run_btn(run_btn),
    .seed(seed), .next_q(next_q), .q(q), .step_pulse(step_pulse),
    .running(running), .period(period), .period_valid(period_valid)
`ifdef SEQ_HISTORY_EN
    , .hist(hist)
`endif
  );

  always #5 hz100 = ~hz100;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] ext_next(input logic [2:0] s, input int md);
    logic [2:0] r;
    if (md == 1) return 3'd0;
    case (s)
      3'd2: r = 3'd4;  3'd4: r = 3'd6;  3'd6: r = 3'd7;  3'd7: r = 3'd3;
      3'd3: r = 3'd0;  3'd0: r = 3'd1;  3'd1: r = 3'd5;  default: r = 3'd2;
    endcase
    return r;
  endfunction

  always_comb next_q = ext_next(q, mode);

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = RST_Q; m_seed = RST_Q; m_run = 1'b0; m_phase = 0;
    m_count = '0; m_period = '0; m_valid = 1'b0; m_hist = {4{RST_Q}};
    for (int i = 0; i < EVN; i++) ev[i] = '0;
  endtask

  // Drive a button level; a rising edge becomes a press SYNC cycles later
  task automatic set_btn(input int b, input logic v);
    logic cur;
    cur = (b == B_LOAD) ? load_btn : (b == B_STEP) ? step_btn : run_btn;
    if (v && !cur) ev[(cyc + SYNC) % EVN][b] = 1'b1;
    case (b)
      B_LOAD:  load_btn = v;
      B_STEP:  step_btn = v;
      default: run_btn  = v;
    endcase
  endtask

  // One clock cycle: check the combinational pulse, advance the model, check registers
  task automatic tick_cycle();
    bit [2:0]   lv;
    logic       tick, commit;
    logic [2:0] nxt;
    lv = ev[cyc % EVN];
    ev[cyc % EVN] = '0;
    tick   = m_run && (m_phase == RATE_DIV - 1);
    commit = !lv[B_LOAD] && !lv[B_RUN] && (m_run ? tick : lv[B_STEP]);
    check("step_pulse", 12'(step_pulse), 12'(commit));
    nxt = ext_next(m_q, mode);
    if (lv[B_LOAD]) begin
      m_q = seed; m_seed = seed; m_run = 1'b0; m_phase = 0;
      m_count = '0; m_period = '0; m_valid = 1'b0; m_hist = {4{seed}};
    end else if (lv[B_RUN]) begin
      m_run = !m_run; m_phase = 0;
    end else begin
      if (m_run) m_phase = (m_phase + 1) % RATE_DIV;
      if (commit) begin
        m_hist = {m_q, m_hist[11:3]};
        if (nxt == m_seed) begin
          m_period = (m_count == 4'd15) ? 4'd15 : m_count + 4'd1;
          m_valid = 1'b1;
          m_count = '0;
        end else begin
          m_count = (m_count == 4'd15) ? 4'd15 : m_count + 4'd1;
        end
        m_q = nxt;
      end
    end
    @(posedge hz100);
    cyc++;
    @(negedge hz100);
    check("q", 12'(q), 12'(m_q));
    check("running", 12'(running), 12'(m_run));
    check("period", 12'(period), 12'(m_period));
    check("period_valid", 12'(period_valid), 12'(m_valid));
`ifdef SEQ_HISTORY_EN
    check("hist", hist, m_hist);
`endif
  endtask

  task automatic press(input int b, input int hold);
    set_btn(b, 1'b1);
    repeat (hold) tick_cycle();
    set_btn(b, 1'b0);
    repeat (SYNC + 1) tick_cycle();
  endtask

  task automatic async_reset();
    set_btn(B_LOAD, 1'b0); set_btn(B_STEP, 1'b0); set_btn(B_RUN, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    check("rst_async_q", 12'(q), 12'(RST_Q));
    check("rst_async_running", 12'(running), 12'd0);
    check("rst_async_valid", 12'(period_valid), 12'd0);
    check("rst_async_period", 12'(period), 12'd0);
    check("rst_async_pulse", 12'(step_pulse), 12'd0);
    @(negedge hz100);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    reset_n = 1'b0; load_btn = 1'b0; step_btn = 1'b0; run_btn = 1'b0; seed = 3'd0;
    model_reset();
    repeat (2) @(negedge hz100);
    check("reset_q", 12'(q), 12'(RST_Q));
    check("reset_running", 12'(running), 12'd0);
    check("reset_period", 12'(period), 12'd0);
    check("reset_valid", 12'(period_valid), 12'd0);
`ifdef SEQ_HISTORY_EN
    check("reset_hist", hist, {4{RST_Q}});
`endif
    reset_n = 1'b1;

    // Manual step: q changes on the third edge, holding gives one step only
    set_btn(B_STEP, 1'b1);
    repeat (2) tick_cycle();
    check("step_latency_before", 12'(q), 12'(RST_Q));
    tick_cycle();
    check("step_latency_after", 12'(q), 12'd4);
    repeat (50) tick_cycle();
    check("step_hold_no_repeat", 12'(q), 12'd4);
    set_btn(B_STEP, 1'b0);
    repeat (SYNC + 1) tick_cycle();

    // Auto run back to the seed, with an ignored step press thrown in
    press(B_RUN, $urandom_range(1, 3));
    for (int i = 0; i < 200 && !m_valid; i++) begin
      if (i == 5) set_btn(B_STEP, 1'b1);
      if (i == 9) set_btn(B_STEP, 1'b0);
      tick_cycle();
    end
    check("run_period", 12'(period), 12'd8);
    check("run_valid", 12'(period_valid), 12'd1);
    check("run_q_home", 12'(q), 12'(RST_Q));

    // Reset while running aborts immediately
    repeat ($urandom_range(0, 6)) tick_cycle();
    async_reset();
    repeat (3) tick_cycle();

    // Three manual steps from reset, then history contents
    for (int i = 0; i < 3; i++) press(B_STEP, $urandom_range(1, 4));
    check("three_steps_q", 12'(q), 12'd7);
`ifdef SEQ_HISTORY_EN
    check("hist_after_3", hist, 12'b110_100_010_010);
`endif

    // Load and step pressed together in IDLE: load wins
    seed = 3'b111;
    set_btn(B_LOAD, 1'b1); set_btn(B_STEP, 1'b1);
    repeat (SYNC + 1) tick_cycle();
    check("load_step_q", 12'(q), 12'd7);
    check("load_step_valid", 12'(period_valid), 12'd0);
    check("load_step_running", 12'(running), 12'd0);
    set_btn(B_LOAD, 1'b0); set_btn(B_STEP, 1'b0);
    repeat (SYNC + 1) tick_cycle();

    // Run and step together: run toggles, step dropped; then load during RUN
    set_btn(B_RUN, 1'b1); set_btn(B_STEP, 1'b1);
    repeat (SYNC + 1) tick_cycle();
    check("run_step_q", 12'(q), 12'd7);
    check("run_step_running", 12'(running), 12'd1);
    set_btn(B_RUN, 1'b0); set_btn(B_STEP, 1'b0);
    repeat ($urandom_range(3, 12)) tick_cycle();
    seed = 3'($urandom_range(0, 7));
    press(B_LOAD, 1);
    check("load_in_run_idle", 12'(running), 12'd0);

    // Fixed point: every step reports period 1
    mode = 1;
    seed = 3'd0;
    press(B_LOAD, 2);
    for (int i = 0; i < 3; i++) press(B_STEP, $urandom_range(1, 4));
    check("fixed_period", 12'(period), 12'd1);
    check("fixed_valid", 12'(period_valid), 12'd1);

    // Seed that is never revisited: measurement stays invalid
    seed = 3'd5;
    press(B_LOAD, 1);
    press(B_RUN, 1);
    repeat (20 * RATE_DIV) tick_cycle();
    check("noreturn_valid", 12'(period_valid), 12'd0);
    check("noreturn_period", 12'(period), 12'd0);
    check("noreturn_q", 12'(q), 12'd0);
    press(B_RUN, 1);
    mode = 0;
    seed = 3'd1;
    press(B_LOAD, 1);
`ifdef SEQ_HISTORY_EN
    check("hist_load_1", hist, 12'b001_001_001_001);
`endif
    check("load_1_q", 12'(q), 12'd1);

    // Random button traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) set_btn(B_LOAD, !load_btn);
      if ($urandom_range(0, 5) == 0)  set_btn(B_STEP, !step_btn);
      if ($urandom_range(0, 11) == 0) set_btn(B_RUN, !run_btn);
      if ($urandom_range(0, 7) == 0)  seed = 3'($urandom_range(0, 7));
      if (i == 200) mode = 1;
      if (i == 260) mode = 0;
      tick_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
